// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM state encoding
// and shift direction constants.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_shift.sv
// bidir_shift_reg: WIDTH-bit bidirectional shift register.
// Ports: clk, rst, en (shift), clr (priority clear), dir, d (serial in), q.
module bidir_shift_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      if (dir == DIR_RIGHT) begin
        q <= {d, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], d};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command-driven sequencer for a bidirectional shift register.
// Ports: cmd_* valid/ready command channel, abort, rsp_* valid/ready
// response channel, q (live register), busy. Optional rsp_parity
// output when SHIFT_SEQ_CTRL_PARITY_EN is defined.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic             cmd_clr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] q,
  output logic             busy
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  ,
  output logic             rsp_parity
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic             dir_r;
  logic [LEN_W-1:0] len_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_sat;
  logic             accept;
  logic             shift_en;
  logic             last;

  assign len_sat  = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign accept   = cmd_valid && cmd_ready;
  assign shift_en = (state == SHIFT) && !abort;
  assign last     = (count + LEN_W'(1)) == len_r;

  // data_r is consumed LSB first by shifting it down each step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r  <= DIR_LEFT;
      len_r  <= '0;
      data_r <= '0;
      count  <= '0;
    end else if (accept) begin
      dir_r  <= cmd_dir;
      len_r  <= len_sat;
      data_r <= cmd_data;
      count  <= '0;
    end else if (shift_en) begin
      data_r <= data_r >> 1;
      count  <= count + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (len_sat == '0) ? RESP : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        // abort wins over a same-cycle rsp_ready
        if (abort || rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  bidir_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .en (shift_en),
    .clr(accept && cmd_clr),
    .dir(dir_r),
    .d  (data_r[0]),
    .q  (q)
  );

  assign cmd_ready = (state == IDLE) && !abort;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  // q does not move in RESP, so it is the completed result
  assign rsp_data  = q;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  assign rsp_parity = rsp_valid & (^q);
`endif

endmodule
